// File: rtl/perf_seq_pkg.sv
// Shared encodings for the performance-counter command sequencer.
package perf_seq_pkg;

  // Client command encodings
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Word offsets inside one counter section
  localparam logic [3:0] OFF_STOP  = 4'd0;  // write: stop, read: time_lo
  localparam logic [3:0] OFF_GO    = 4'd1;  // write: go,   read: time_hi
  localparam logic [3:0] OFF_EVENT = 4'd2;  // read: event count

  localparam int SEC_STRIDE = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_RSP
  } state_t;

  // Base slave address of a section
  function automatic logic [3:0] sec_base(input logic [1:0] sec);
    return 4'(int'(sec) * SEC_STRIDE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or after the pointer wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  logic [ID_W-1:0] ptr;
  int              idx;

  // Scan from the pointer, wrapping, and pick the first active request
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (en && !grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  // Pointer moves just past the winner; untouched when nobody is granted
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (grant_any)
      ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  end

endmodule

// File: rtl/perf_counter_sequencer.sv
// Shares the performance-counter control slave between NUM_REQ clients:
// arbitrates commands and sequences slave writes and 3-word snapshot reads.
module perf_counter_sequencer
  import perf_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [2*NUM_REQ-1:0] req_sec,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [95:0]          rsp_data,
  output logic                 busy,
  output logic [3:0]           pc_address,
  output logic                 pc_write,
  output logic                 pc_begintransfer,
  output logic [31:0]          pc_writedata,
  input  logic [31:0]          pc_readdata
);

  state_t          state, nxt;
  logic [1:0]      op_q, sec_q;
  logic [ID_W-1:0] id_q;
  logic [31:0]     cap_lo, cap_hi;

  logic            g_any;
  logic [ID_W-1:0] g_id;
  logic [1:0]      g_op, g_sec, cur_op;
  logic [3:0]      cur_base;
  logic [3:0]      n_addr;
  logic            n_write;
  logic [31:0]     n_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .en        (state == S_IDLE && !reset),
    .grant     (req_ready),
    .grant_id  (g_id),
    .grant_any (g_any)
  );

  assign g_op  = req_op[int'(g_id)*2 +: 2];
  assign g_sec = req_sec[int'(g_id)*2 +: 2];
  assign busy  = (state != S_IDLE);

  // Next state plus the slave signals for that state, registered below
  always_comb begin
    nxt      = state;
    n_addr   = '0;
    n_write  = 1'b0;
    n_wdata  = '0;
    cur_op   = (state == S_IDLE) ? g_op : op_q;
    cur_base = sec_base((state == S_IDLE) ? g_sec : sec_q);
    case (state)
      S_IDLE:  if (g_any) nxt = (g_op == OP_READ) ? S_RD0 : S_WR;
      S_WR:    nxt = S_IDLE;
      S_RD0:   nxt = S_RD1;
      S_RD1:   nxt = S_RD2;
      S_RD2:   nxt = S_RD3;
      S_RD3:   nxt = S_RSP;
      S_RSP:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    case (nxt)
      S_WR: begin
        n_write = 1'b1;
        case (cur_op)
          OP_START: n_addr = cur_base + OFF_GO;
          OP_STOP:  n_addr = cur_base + OFF_STOP;
          OP_CLEAR: n_wdata = 32'd1;  // global clear lives at address 0
          default:  ;
        endcase
      end
      S_RD0:   n_addr = cur_base + OFF_STOP;
      S_RD1:   n_addr = cur_base + OFF_GO;
      S_RD2:   n_addr = cur_base + OFF_EVENT;
      default: ;
    endcase
  end

  // State, command latch, registered slave port and snapshot capture.
  // Read data lags the address by one cycle, so RD1..RD3 capture lo/hi/event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      op_q             <= '0;
      sec_q            <= '0;
      id_q             <= '0;
      cap_lo           <= '0;
      cap_hi           <= '0;
      pc_address       <= '0;
      pc_write         <= 1'b0;
      pc_begintransfer <= 1'b0;
      pc_writedata     <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_data         <= '0;
    end else begin
      state            <= nxt;
      pc_address       <= n_addr;
      pc_write         <= n_write;
      pc_begintransfer <= n_write;
      pc_writedata     <= n_wdata;
      rsp_valid        <= (nxt == S_RSP);
      if (state == S_IDLE && g_any) begin
        op_q  <= g_op;
        sec_q <= g_sec;
        id_q  <= g_id;
      end
      case (state)
        S_RD1: cap_lo <= pc_readdata;
        S_RD2: cap_hi <= pc_readdata;
        S_RD3: begin
          rsp_data <= {pc_readdata, cap_hi, cap_lo};
          rsp_id   <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Scoreboard bench: stimulus queues expected grants/writes/responses,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_perf_counter_sequencer;

  localparam int NR = 4;

  typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [1:0] id; logic [95:0] d; } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [7:0]  req_op = '0;
  logic [7:0]  req_sec = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [95:0] rsp_data;
  logic        busy;
  logic [3:0]  pc_address;
  logic        pc_write;
  logic        pc_begintransfer;
  logic [31:0] pc_writedata;
  logic [31:0] pc_readdata = '0;

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_g = 0;

  logic [3:0] exp_g[$];
  wr_t        exp_w[$];
  rsp_t       exp_r[$];
  int         gcyc[$];

  perf_counter_sequencer #(.NUM_REQ(NR), .ID_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sec(req_sec),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy),
    .pc_address(pc_address), .pc_write(pc_write),
    .pc_begintransfer(pc_begintransfer), .pc_writedata(pc_writedata),
    .pc_readdata(pc_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered slave: data for an address appears one cycle later
  always @(posedge clk) pc_readdata <= mem[pc_address];

  // Monitor
  always @(negedge clk) begin
    if (req_ready != 0) begin
      checks++;
      if (exp_g.size() == 0) begin
        errors++; $display("FAIL grant_unexpected got=%b", req_ready);
      end else begin
        logic [3:0] e;
        e = exp_g.pop_front();
        if (req_ready !== e) begin
          errors++; $display("FAIL grant got=%b exp=%b", req_ready, e);
        end
      end
      last_g = cyc;
      gcyc.push_back(cyc);
    end
    if (pc_write) begin
      checks++;
      if (exp_w.size() == 0) begin
        errors++; $display("FAIL write_unexpected addr=%0d data=%0h", pc_address, pc_writedata);
      end else begin
        wr_t e;
        e = exp_w.pop_front();
        if (pc_address !== e.a || pc_writedata !== e.d || pc_begintransfer !== 1'b1 || cyc != last_g + 1) begin
          errors++;
          $display("FAIL write got a=%0d d=%0h bt=%b lat=%0d exp a=%0d d=%0h bt=1 lat=1",
                   pc_address, pc_writedata, pc_begintransfer, cyc - last_g, e.a, e.d);
        end
      end
    end
    if (rsp_valid) begin
      checks++;
      if (exp_r.size() == 0) begin
        errors++; $display("FAIL rsp_unexpected id=%0d data=%h", rsp_id, rsp_data);
      end else begin
        rsp_t e;
        e = exp_r.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.d || cyc != last_g + 5) begin
          errors++;
          $display("FAIL rsp got id=%0d d=%h lat=%0d exp id=%0d d=%h lat=5",
                   rsp_id, rsp_data, cyc - last_g, e.id, e.d);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic set_req(input int c, input logic [1:0] op, input logic [1:0] sec);
    req_op[2*c +: 2]  = op;
    req_sec[2*c +: 2] = sec;
    req_valid[c]      = 1'b1;
  endtask

  // Drop each client's valid after its grant; stop when all served and idle
  task automatic run(input int budget);
    int n;
    logic [3:0] seen;
    n = 0;
    while ((req_valid != 0 || busy) && n < budget) begin
      @(negedge clk); seen = req_ready;
      @(posedge clk); #1; req_valid = req_valid & ~seen;
      n++;
    end
    chk("run_budget", 128'(n >= budget), 128'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[4] = 32'h11; mem[5] = 32'h22; mem[6] = 32'h33;

    // Reset, then idle: everything quiet
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs",
          128'({req_ready, rsp_valid, rsp_id, rsp_data, busy, pc_address, pc_write, pc_begintransfer, pc_writedata}),
          128'(0));
    end

    // Client 1 START sec 2 -> write at 9, data 0; busy clears a cycle later
    exp_g.push_back(4'b0010); exp_w.push_back('{4'd9, 32'd0});
    @(posedge clk); #1; set_req(1, 2'b00, 2'd2);
    @(negedge clk);
    @(posedge clk); #1; req_valid[1] = 1'b0;
    @(negedge clk); chk("busy_in_wr", 128'(busy), 128'(1));
    @(negedge clk); chk("busy_after_wr", 128'(busy), 128'(0));

    // Pointer 0, clients 0,1,3 together -> 0,1,3 on back-to-back IDLE cycles
    do_reset();
    gcyc.delete();
    exp_g.push_back(4'b0001); exp_w.push_back('{4'd1,  32'd0});
    exp_g.push_back(4'b0010); exp_w.push_back('{4'd4,  32'd0});
    exp_g.push_back(4'b1000); exp_w.push_back('{4'd13, 32'd0});
    set_req(0, 2'b00, 2'd0); set_req(1, 2'b01, 2'd1); set_req(3, 2'b00, 2'd3);
    run(40);
    chk("rr_grant_count", 128'(gcyc.size()), 128'(3));
    if (gcyc.size() == 3) begin
      chk("rr_gap01", 128'(gcyc[1] - gcyc[0]), 128'(2));
      chk("rr_gap13", 128'(gcyc[2] - gcyc[1]), 128'(2));
    end

    // READ sec 1 by client 2: addresses 4,5,6 then snapshot
    exp_g.push_back(4'b0100);
    exp_r.push_back('{2'd2, 96'h00000033_00000022_00000011});
    set_req(2, 2'b10, 2'd1);
    @(negedge clk);
    @(posedge clk); #1; req_valid[2] = 1'b0;
    @(negedge clk); chk("rd0_addr", 128'(pc_address), 128'(4));
    chk("rd0_no_write", 128'({pc_write, pc_begintransfer}), 128'(0));
    @(negedge clk); chk("rd1_addr", 128'(pc_address), 128'(5));
    @(negedge clk); chk("rd2_addr", 128'(pc_address), 128'(6));
    run(20);
    chk("rsp_hold", 128'(rsp_data), 128'(96'h00000033_00000022_00000011));

    // CLEAR from client 3 ignores its section
    exp_g.push_back(4'b1000); exp_w.push_back('{4'd0, 32'd1});
    set_req(3, 2'b11, 2'd3);
    run(20);

    // Reset during RD2: read aborted, pointer back to 0, pending re-arbitrated
    exp_g.push_back(4'b0100);
    exp_g.push_back(4'b0010); exp_w.push_back('{4'd1,  32'd0});
    exp_g.push_back(4'b1000); exp_w.push_back('{4'd12, 32'd0});
    set_req(2, 2'b10, 2'd1);
    @(negedge clk);
    @(posedge clk); #1; req_valid[2] = 1'b0;
    set_req(1, 2'b00, 2'd0); set_req(3, 2'b01, 2'd3);
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("abort_idle_busy", 128'(busy), 128'(0));
    chk("abort_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("abort_regrant", 128'(req_ready), 128'(4'b0010));
    begin
      logic [3:0] s;
      s = req_ready;
      @(posedge clk); #1; req_valid = req_valid & ~s;
    end
    run(40);
    repeat (4) @(negedge clk);

    chk("left_grants", 128'(exp_g.size()), 128'(0));
    chk("left_writes", 128'(exp_w.size()), 128'(0));
    chk("left_rsps",   128'(exp_r.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
